// File: rtl/ball_link_pkg.sv
// ball_link_pkg: shared state codes, register map and ball packet type for the ball link.
// Used by the transmitter (ball_packet_tx) and by the slave register file on the opponent board.
`timescale 1ns/1ps
package ball_link_pkg;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_LOAD  = 3'd1;
  localparam state_t S_REQ   = 3'd2;
  localparam state_t S_WAIT  = 3'd3;
  localparam state_t S_NEXT  = 3'd4;
  localparam state_t S_RETRY = 3'd5;
  localparam state_t S_DONE  = 3'd6;
  localparam state_t S_ERR   = 3'd7;
  localparam logic [2:0] REG_Y0    = 3'd0;
  localparam logic [2:0] REG_Y1    = 3'd1;
  localparam logic [2:0] REG_VY    = 3'd2;
  localparam logic [2:0] REG_GRAV  = 3'd3;
  localparam logic [2:0] REG_SPEED = 3'd4;
  localparam logic [2:0] REG_WIN   = 3'd5;
  typedef struct packed {
    logic [9:0] y;
    logic [7:0] vy;
    logic [1:0] grav;
    logic [7:0] speed;
    logic       win;
  } ball_pkt_t;
  function automatic logic [7:0] reg_payload(ball_pkt_t p, logic [2:0] idx);
    return idx == REG_Y0    ? p.y[7:0] :
           idx == REG_Y1    ? {6'b0, p.y[9:8]} :
           idx == REG_VY    ? p.vy :
           idx == REG_GRAV  ? {6'b0, p.grav} :
           idx == REG_SPEED ? p.speed :
           idx == REG_WIN   ? {7'b0, p.win} : 8'h00;
  endfunction
endpackage

// File: rtl/ball_packet_tx.sv
// ball_packet_tx: sends a snapshotted ball hand-off packet as six I2C register writes.
// Ports: clk_25MHZ/reset (async active-low, sync release); ball_send_trigger + ball_* payload
// inputs; tx_req/tx_slave_addr/tx_reg_addr/tx_data towards the I2C master, tx_ack/tx_nack back;
// busy, packet_done, packet_error status and contrl_led = {state, retry[1:0], reg_idx}.
`timescale 1ns/1ps
module ball_packet_tx
  import ball_link_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR     = 7'h42,
  parameter int         MAX_RETRY      = 3,
  parameter int         TIMEOUT_CYCLES = 25000
) (
  input  logic       clk_25MHZ,
  input  logic       reset,
  input  logic       ball_send_trigger,
  input  logic [9:0] ball_y,
  input  logic [7:0] ball_vy,
  input  logic [1:0] gravity_counter,
  input  logic [7:0] ball_speed,
  input  logic       win_flag,
  output logic       tx_req,
  output logic [6:0] tx_slave_addr,
  output logic [7:0] tx_reg_addr,
  output logic [7:0] tx_data,
  input  logic       tx_ack,
  input  logic       tx_nack,
  output logic       busy,
  output logic       packet_done,
  output logic       packet_error,
  output logic [7:0] contrl_led
);
  localparam int RW = (MAX_RETRY < 4) ? 2 : $clog2(MAX_RETRY + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic          rst_sync_q;
  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [TW-1:0] tmo_q, tmo_d;
  ball_pkt_t     snap_q, snap_d, pend_q, pend_d, in_pkt;
  logic          pend_v_q, pend_v_d;
  logic          tmo_hit, fail;
  // Assertion reaches every flop immediately; release is seen one edge late so the
  // first edge after release is still inside reset.
  always_ff @(posedge clk_25MHZ or negedge reset)
    if (!reset) rst_sync_q <= 1'b0;
    else rst_sync_q <= 1'b1;
  assign in_pkt  = '{y: ball_y, vy: ball_vy, grav: gravity_counter, speed: ball_speed, win: win_flag};
  assign tmo_hit = state_q == S_WAIT && tmo_q == TW'(TIMEOUT_CYCLES - 1);
  // A timeout or a simultaneous ack+nack counts as a NACK.
  assign fail    = tx_nack || tmo_hit;
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    retry_d  = retry_q;
    tmo_d    = tmo_q;
    snap_d   = snap_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    if (ball_send_trigger && state_q != S_IDLE) begin
      pend_d   = in_pkt;
      pend_v_d = 1'b1;
    end
    case (state_q)
      // The LOAD work is done on the IDLE exit edge so tx_req follows the trigger by one cycle.
      S_IDLE: if (ball_send_trigger) begin
        snap_d  = in_pkt;
        idx_d   = REG_Y0;
        retry_d = '0;
        state_d = S_REQ;
      end
      S_LOAD: begin
        snap_d   = pend_q;
        idx_d    = REG_Y0;
        retry_d  = '0;
        pend_v_d = ball_send_trigger;
        state_d  = S_REQ;
      end
      S_REQ: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        tmo_d = tmo_q + TW'(1);
        if (fail) begin
          state_d = retry_q == RW'(MAX_RETRY) ? S_ERR : S_RETRY;
          retry_d = retry_q == RW'(MAX_RETRY) ? retry_q : retry_q + RW'(1);
        end else if (tx_ack) begin
          state_d = idx_q == REG_WIN ? S_DONE : S_NEXT;
          idx_d   = idx_q == REG_WIN ? idx_q : idx_q + 3'd1;
          retry_d = '0;
        end
      end
      S_NEXT, S_RETRY: state_d = S_REQ;
      default: begin
        state_d = (pend_v_q || ball_send_trigger) ? S_LOAD : S_IDLE;
        idx_d   = REG_Y0;
        retry_d = '0;
      end
    endcase
  end
  always_ff @(posedge clk_25MHZ or negedge rst_sync_q)
    if (!rst_sync_q) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      retry_q  <= '0;
      tmo_q    <= '0;
      snap_q   <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      retry_q  <= retry_d;
      tmo_q    <= tmo_d;
      snap_q   <= snap_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
    end
  assign tx_req        = state_q == S_REQ || state_q == S_WAIT;
  assign tx_slave_addr = SLAVE_ADDR;
  assign tx_reg_addr   = {5'b0, idx_q};
  assign tx_data       = reg_payload(snap_q, idx_q);
  assign busy          = state_q != S_IDLE;
  assign packet_done   = state_q == S_DONE;
  assign packet_error  = state_q == S_ERR;
  assign contrl_led    = {state_q, retry_q[1:0], idx_q};
endmodule

// File: tb/tb_ball_packet_tx.sv
// tb_ball_packet_tx: scoreboard bench for ball_packet_tx with a scripted I2C master model.
`timescale 1ns/1ps
module tb_ball_packet_tx;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ball_send_trigger = 1'b0;
  logic [9:0] ball_y = '0;
  logic [7:0] ball_vy = '0;
  logic [1:0] gravity_counter = '0;
  logic [7:0] ball_speed = '0;
  logic       win_flag = 1'b0;
  logic       tx_req, tx_ack, tx_nack, busy, packet_done, packet_error;
  logic [6:0] tx_slave_addr;
  logic [7:0] tx_reg_addr, tx_data, contrl_led;
  int checks = 0;
  int failures = 0;
  logic [15:0] wq[$];
  byte eq[$];
  byte rq[$];
  always #20 clk = ~clk;
  ball_packet_tx #(.SLAVE_ADDR(7'h42), .MAX_RETRY(3), .TIMEOUT_CYCLES(100)) dut (
    .clk_25MHZ(clk), .reset(reset), .ball_send_trigger(ball_send_trigger),
    .ball_y(ball_y), .ball_vy(ball_vy), .gravity_counter(gravity_counter),
    .ball_speed(ball_speed), .win_flag(win_flag), .tx_req(tx_req),
    .tx_slave_addr(tx_slave_addr), .tx_reg_addr(tx_reg_addr), .tx_data(tx_data),
    .tx_ack(tx_ack), .tx_nack(tx_nack), .busy(busy), .packet_done(packet_done),
    .packet_error(packet_error), .contrl_led(contrl_led)
  );
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic wr(logic [7:0] r, logic [7:0] d);
    wq.push_back({r, d});
  endtask
  task automatic trig(logic [9:0] y, logic [7:0] vy, logic [1:0] g, logic [7:0] s, logic w);
    @(posedge clk); #5;
    ball_y = y; ball_vy = vy; gravity_counter = g; ball_speed = s; win_flag = w;
    ball_send_trigger = 1'b1;
    @(posedge clk); #5;
    ball_send_trigger = 1'b0;
    ball_y = 10'($urandom); ball_vy = 8'($urandom); gravity_counter = 2'($urandom);
    ball_speed = 8'($urandom); win_flag = 1'($urandom);
  endtask
  task automatic wait_idle(string name);
    int n = 0;
    @(negedge clk);
    while (busy && n < 5000) begin @(negedge clk); n++; end
    chk(name, busy, 0);
  endtask
  task automatic chk_zero(string tag);
    chk({tag, "_tx_req"}, tx_req, 0);
    chk({tag, "_tx_reg_addr"}, tx_reg_addr, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_packet_done"}, packet_done, 0);
    chk({tag, "_packet_error"}, packet_error, 0);
    chk({tag, "_contrl_led"}, contrl_led, 0);
  endtask
  // Master model: one scripted response per request; 'A' ack, 'N' nack, 'B' both, 'T' silent.
  initial begin
    byte r;
    int n;
    tx_ack = 1'b0;
    tx_nack = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_req) begin
        r = rq.size() > 0 ? rq.pop_front() : "A";
        if (r == "T") begin
          n = 1;
          while (tx_req && n < 1000) begin @(negedge clk); if (tx_req) n++; end
          if (reset) chk("timeout_req_cycles", n, 101);
        end else begin
          @(posedge clk); #5;
          tx_ack = (r == "A" || r == "B");
          tx_nack = (r == "N" || r == "B");
          @(posedge clk); #5;
          tx_ack = 1'b0;
          tx_nack = 1'b0;
        end
      end
    end
  end
  // Monitor: checks each new write against the scoreboard and its stability while held.
  initial begin
    logic prev = 1'b0;
    logic [7:0] ha = '0, hd = '0;
    logic [15:0] w;
    byte e;
    forever begin
      @(negedge clk);
      if (tx_req && !prev) begin
        if (wq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_write actual=%0h:%0h required=none", tx_reg_addr, tx_data);
        end else begin
          w = wq.pop_front();
          chk("write_reg", tx_reg_addr, w[15:8]);
          chk("write_data", tx_data, w[7:0]);
          chk("slave_addr", tx_slave_addr, 7'h42);
        end
        ha = tx_reg_addr;
        hd = tx_data;
      end else if (tx_req) begin
        chk("hold_reg", tx_reg_addr, ha);
        chk("hold_data", tx_data, hd);
      end
      if (packet_done || packet_error) begin
        e = packet_done ? "D" : "E";
        if (eq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_event actual=%c required=none", e);
        end else chk("event", e, eq.pop_front());
      end
      prev = tx_req;
    end
  end
  initial begin
    #3000000;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end
  initial begin
    int n;
    repeat (3) @(posedge clk);
    #5 chk_zero("reset");
    @(posedge clk); #10 reset = 1'b1;
    ball_y = 10'h3FF; ball_send_trigger = 1'b1;
    @(posedge clk); #5 ball_send_trigger = 1'b0;
    @(negedge clk) chk("first_edge_trigger_ignored", busy, 0);
    repeat (4) @(negedge clk);
    chk("still_idle", busy, 0);
    wr(0, 8'hA5); wr(1, 8'h02); wr(2, 8'hFD); wr(3, 8'h02); wr(4, 8'h05); wr(5, 8'h00);
    eq.push_back("D");
    trig(10'h2A5, 8'hFD, 2'd2, 8'h05, 1'b0);
    @(negedge clk);
    chk("latency_tx_req", tx_req, 1);
    chk("latency_reg0", tx_reg_addr, 0);
    chk("busy_in_packet", busy, 1);
    wait_idle("idle_after_basic");
    rq = '{"A", "A", "N", "N", "A", "A", "A", "A"};
    wr(0, 8'hC3); wr(1, 8'h01); wr(2, 8'h7F); wr(2, 8'h7F); wr(2, 8'h7F);
    wr(3, 8'h01); wr(4, 8'h20); wr(5, 8'h01);
    eq.push_back("D");
    trig(10'h1C3, 8'h7F, 2'd1, 8'h20, 1'b1);
    wait_idle("idle_after_nack_retry");
    rq = '{"N", "B", "N", "N"};
    repeat (4) wr(0, 8'h11);
    eq.push_back("E");
    trig(10'h311, 8'h80, 2'd3, 8'hFF, 1'b1);
    n = 0;
    @(negedge clk);
    while (!packet_error && n < 2000) begin @(negedge clk); n++; end
    chk("error_pulse_seen", packet_error, 1);
    @(negedge clk) chk("busy_low_after_error", busy, 0);
    wait_idle("idle_after_error");
    rq = '{"T", "T", "T", "T"};
    repeat (4) wr(0, 8'hAA);
    eq.push_back("E");
    trig(10'h0AA, 8'h00, 2'd0, 8'h00, 1'b0);
    wait_idle("idle_after_timeout");
    wr(0, 8'h00); wr(1, 8'h03); wr(2, 8'h01); wr(3, 8'h00); wr(4, 8'h10); wr(5, 8'h00);
    eq.push_back("D");
    wr(0, 8'h02); wr(1, 8'h00); wr(2, 8'h44); wr(3, 8'h02); wr(4, 8'h55); wr(5, 8'h00);
    eq.push_back("D");
    trig(10'h300, 8'h01, 2'd0, 8'h10, 1'b0);
    trig(10'h001, 8'h22, 2'd1, 8'h33, 1'b1);
    trig(10'h002, 8'h44, 2'd2, 8'h55, 1'b0);
    n = 0;
    @(negedge clk);
    while (!packet_done && n < 2000) begin @(negedge clk); n++; end
    chk("first_done_seen", packet_done, 1);
    n = 0;
    do begin @(negedge clk); n++; chk("busy_across_pending", busy, 1); end while (!tx_req && n < 10);
    chk("pending_start_gap", n, 2);
    wait_idle("idle_after_pending");
    rq = '{"A", "A", "A", "T"};
    wr(0, 8'h55); wr(1, 8'h01); wr(2, 8'h9C); wr(3, 8'h03);
    trig(10'h155, 8'h9C, 2'd3, 8'h07, 1'b1);
    n = 0;
    @(negedge clk);
    while (!(tx_req && tx_reg_addr == 3) && n < 500) begin @(negedge clk); n++; end
    chk("reached_reg3", tx_reg_addr, 3);
    repeat (3) @(negedge clk);
    #5 reset = 1'b0;
    #1 chk_zero("midreset");
    repeat (2) @(posedge clk);
    #10 reset = 1'b1;
    wr(0, 8'hF0); wr(1, 8'h02); wr(2, 8'h01); wr(3, 8'h00); wr(4, 8'h09); wr(5, 8'h00);
    eq.push_back("D");
    @(posedge clk); #5;
    ball_y = 10'h2F0; ball_vy = 8'h01; gravity_counter = 2'd0; ball_speed = 8'h09; win_flag = 1'b0;
    ball_send_trigger = 1'b1;
    @(posedge clk); #5 ball_send_trigger = 1'b0;
    @(negedge clk);
    chk("second_edge_trigger_req", tx_req, 1);
    chk("second_edge_trigger_reg0", tx_reg_addr, 0);
    wait_idle("idle_after_reset_restart");
    repeat (5) @(negedge clk);
    chk("writes_left", wq.size(), 0);
    chk("events_left", eq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
